// File: rtl/adc_i2c_pkg.sv
// Shared definitions for the ADC I2C responder: FSM states, default address
// and byte/bit-count constants.
package adc_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h48;
  localparam int BYTE_BITS = 8;
  localparam int BIT_CNT_W = 4;
  // bit_cnt value once a whole byte has been clocked, and at the address R/W bit
  localparam logic [BIT_CNT_W-1:0] FULL_CNT  = BIT_CNT_W'(BYTE_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT  = BIT_CNT_W'(BYTE_BITS - 1);

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and detects SCL edges plus
// START/STOP conditions on the synchronized levels.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // bit 1 = SCL, bit 0 = SDA; all flops reset to 1 (bus idle)
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] hist_q, hist_d;

  always_comb begin
    meta_d = {scl_in, sda_in};
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  always_comb begin
    sda_s     = sync_q[0];
    scl_rise  =  sync_q[1] & ~hist_q[1];
    scl_fall  = ~sync_q[1] &  hist_q[1];
    start_det =  sync_q[1] & hist_q[1] &  hist_q[0] & ~sync_q[0];
    stop_det  =  sync_q[1] & hist_q[1] & ~hist_q[0] &  sync_q[0];
  end

endmodule

// File: rtl/adc_i2c_responder.sv
// I2C target returning a latched ADC sample on reads (upper byte, lower byte,
// repeating) and capturing control bytes on writes.
module adc_i2c_responder
  import adc_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sample_req,
  output logic [7:0]          ctrl_byte,
  output logic                ctrl_valid,
  output logic                busy,
  output state_t              dbg_state
);

  // Handshake: ctrl_valid and sample_req are single-cycle strobes; ctrl_byte
  // is stable from its ctrl_valid pulse until the next one.

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_BITS-1:0]   shift_q, shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic [7:0]             ctrl_byte_q, ctrl_byte_d;
  logic                   ctrl_valid_q, ctrl_valid_d;
  logic                   sample_req_q, sample_req_d;
  logic [SAMPLE_W-1:0]    shadow_q, shadow_d;
  logic                   byte_sel_q, byte_sel_d;

  logic [15:0] sample_ext;
  logic [7:0]  byte_hi, byte_lo, byte_nxt;

  always_comb begin
    sample_ext = 16'(shadow_q);
    byte_hi    = sample_ext[15:8];
    byte_lo    = sample_ext[7:0];
    byte_nxt   = byte_sel_q ? byte_lo : byte_hi;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    ctrl_byte_d  = ctrl_byte_q;
    ctrl_valid_d = 1'b0;
    sample_req_d = 1'b0;
    shadow_d     = shadow_q;
    byte_sel_d   = byte_sel_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise && bit_cnt_q < FULL_CNT) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            // Read to us: freeze the sample on the R/W bit rise
            if (bit_cnt_q == LAST_CNT && sda_s && shift_q[6:0] == DEV_ADDR) begin
              shadow_d     = sample;
              sample_req_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == FULL_CNT) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (shift_q[0]) begin
              state_d    = ST_RD_DATA;
              sda_oe_d   = ~byte_hi[7];
              shift_d    = {byte_hi[6:0], 1'b0};
              bit_cnt_d  = BIT_CNT_W'(1);
              byte_sel_d = 1'b1;
            end else begin
              state_d   = ST_WR_DATA;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise && bit_cnt_q < FULL_CNT) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall && bit_cnt_q == FULL_CNT) begin
            state_d      = ST_WR_ACK;
            sda_oe_d     = 1'b1;
            ctrl_byte_d  = shift_q;
            ctrl_valid_d = 1'b1;
            bit_cnt_d    = '0;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        ST_RD_DATA: begin
          // Each falling edge presents the next bit; after bit 0 release SDA
          if (scl_fall) begin
            if (bit_cnt_q == FULL_CNT) begin
              state_d  = ST_RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_s) begin
            state_d = ST_IGNORE;
          end else if (scl_fall) begin
            state_d    = ST_RD_DATA;
            sda_oe_d   = ~byte_nxt[7];
            shift_d    = {byte_nxt[6:0], 1'b0};
            bit_cnt_d  = BIT_CNT_W'(1);
            byte_sel_d = ~byte_sel_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      ctrl_byte_q  <= 8'h00;
      ctrl_valid_q <= 1'b0;
      sample_req_q <= 1'b0;
      shadow_q     <= '0;
      byte_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      ctrl_byte_q  <= ctrl_byte_d;
      ctrl_valid_q <= ctrl_valid_d;
      sample_req_q <= sample_req_d;
      shadow_q     <= shadow_d;
      byte_sel_q   <= byte_sel_d;
    end
  end

  always_comb begin
    sda_oe     = sda_oe_q;
    busy       = busy_q;
    ctrl_byte  = ctrl_byte_q;
    ctrl_valid = ctrl_valid_q;
    sample_req = sample_req_q;
    dbg_state  = state_q;
  end

endmodule

// File: doc/adc_i2c_responder.md
ADC_I2C_RESPONDER -- requirements
Module: adc_i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h48, 7-bit I2C target address responded to.
REQ-002 SHALL have parameter SAMPLE_W, default 12, width of returned ADC sample.
REQ-003 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 scl_in  input  1  I2C SCL line level (asynchronous to clk).
REQ-006 sda_in  input  1  I2C SDA line level (asynchronous to clk).
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 sample  input  SAMPLE_W  current conversion value to return on reads.
REQ-009 sample_req  output  1  one-clk pulse when a read transaction latches sample.
REQ-010 ctrl_byte  output  8  last control byte written by the initiator.
REQ-011 ctrl_valid  output  1  one-clk pulse when ctrl_byte updates.
REQ-012 busy  output  1  high from addressed START until STOP or address mismatch.

Function
REQ-013 scl_in/sda_in SHALL pass a 2-flop synchronizer plus one history flop; all edges detected on synchronized levels.
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be recognized in any state.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 START (incl. repeated START) SHALL move to ADDR, clear bit counter, release sda_oe; STOP SHALL move to IDLE, release sda_oe, deassert busy.
REQ-017 Data bits SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on SCL falling edge.
REQ-018 ADDR: after 8 bits, address match -> ADDR_ACK (sda_oe=1 from 8th falling edge to 9th falling edge); mismatch -> IGNORE, no ACK, busy=0.
REQ-019 IGNORE SHALL hold sda_oe=0 until START or STOP.
REQ-020 R/W=0 -> WR_DATA; each received byte SHALL be ACKed (WR_ACK), update ctrl_byte, pulse ctrl_valid once.
REQ-021 R/W=1 -> latch sample into shadow register at 8th-bit SCL rise of address byte, pulse sample_req once, then RD_DATA.
REQ-022 Read stream: byte0 = {zero-pad, sample[SAMPLE_W-1:8]} (upper bits), byte1 = sample[7:0], alternating byte0/byte1 from the same latched value; zero-padding when SAMPLE_W<16.
REQ-023 RD_DATA: sda_oe = ~bit (drive low for 0) per bit; released during 9th clock (RD_ACK) to sample initiator ACK at SCL rise.
REQ-024 RD_ACK: ACK (SDA low) -> next byte in RD_DATA; NACK -> IGNORE until STOP/START; new sample SHALL NOT be latched mid-transaction.
REQ-025 SCL idle high with no edges SHALL leave state unchanged indefinitely (no timeout).
REQ-026 SDA transitions while SCL high other than START/STOP SHALL NOT be generated by the block.

Reset
REQ-027 rst low SHALL immediately force: state IDLE, sda_oe=0, sample_req=0, ctrl_valid=0, busy=0, ctrl_byte=8'h00, synchronizer flops=1 (bus idle).
REQ-028 Reset mid-transaction SHALL release SDA within the same cycle as assertion (asynchronous); after release, block waits for a fresh START.

Structure
REQ-029 State enum, DEV_ADDR default and byte-count constants SHALL live in a shared package (adc_i2c_pkg).
REQ-030 Sub-module i2c_line_sync SHALL contain synchronizers and START/STOP/SCL-edge detection; FSM and shift register in top.

Verification
REQ-031 Write 0x90,0x40,STOP -> ACK on both bytes, ctrl_byte=0x40, one ctrl_valid pulse, busy low after STOP.
REQ-032 sample=12'hABC, read 0x91, master ACK, NACK -> bytes 0x0A,0xBC, one sample_req pulse, sda_oe=0 after NACK.
REQ-033 Address 0x92 -> no ACK (SDA high on 9th clock), busy=0, ctrl_byte unchanged.
REQ-034 Write 0x90,0x01, repeated START, read 0x91 for 4 bytes with sample changing mid-read -> 0x0A,0xBC,0x0A,0xBC from latched value.
REQ-035 STOP injected mid-byte of read -> sda_oe=0 next cycles, state IDLE, next transaction normal.
REQ-036 rst asserted while driving ACK -> sda_oe=0 immediately, all outputs at reset values, following write ACKed correctly.
